// File: rtl/uart_prog_rx.sv
// UART program loader: receives 8N1 bytes, packs them little-endian into 32-bit
// words and writes them to sequential program-memory addresses until END_WORD arrives.
module uart_prog_rx #(
  parameter int unsigned CLKS_PER_BIT = 347,
  parameter int unsigned ADDR_W       = 10,
  parameter logic [31:0] END_WORD     = 32'h0000_0FFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_i,
  output logic              ready_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [31:0]       wdata_o,
  output logic              done_o,
  output logic              frame_err_o
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF =
    CNT_W'((CLKS_PER_BIT / 2 > 0) ? (CLKS_PER_BIT / 2 - 1) : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  function automatic logic [31:0] place_byte(input logic [31:0] word,
                                             input logic [7:0]  byte_val,
                                             input logic [1:0]  idx);
    logic [31:0] res;
    res = word;
    case (idx)
      2'd0:    res[7:0]   = byte_val;
      2'd1:    res[15:8]  = byte_val;
      2'd2:    res[23:16] = byte_val;
      2'd3:    res[31:24] = byte_val;
      default: res        = word;
    endcase
    return res;
  endfunction

  state_e            state_q, state_d;
  logic              rx_meta_q, rx_sync_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       word_q, word_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              ferr_q, ferr_d;

  logic              cnt_last_s;
  logic              start_sample_s;
  logic              data_sample_s;
  logic              stop_sample_s;
  logic              byte_ok_s;
  logic              frame_bad_s;
  logic              word_done_s;
  logic              term_s;
  logic              write_s;
  logic [31:0]       full_word_s;

  // rx synchronizer; idles high so reset does not look like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!rx_sync_q) state_d = S_START;
        else            state_d = S_IDLE;
      end
      S_START: begin
        if (start_sample_s) state_d = rx_sync_q ? S_IDLE : S_DATA;
        else                state_d = S_START;
      end
      S_DATA: begin
        if (data_sample_s && (bit_idx_q == 3'd7)) state_d = S_STOP;
        else                                      state_d = S_DATA;
      end
      S_STOP: begin
        if (stop_sample_s) state_d = term_s ? S_DONE : S_IDLE;
        else               state_d = S_STOP;
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: mid-bit sample strobes and the byte/word events they produce
  always_comb begin
    cnt_last_s     = (cnt_q == CNT_LAST);
    start_sample_s = 1'b0;
    data_sample_s  = 1'b0;
    stop_sample_s  = 1'b0;
    case (state_q)
      S_START: start_sample_s = (cnt_q == CNT_HALF);
      S_DATA:  data_sample_s  = cnt_last_s;
      S_STOP:  stop_sample_s  = cnt_last_s;
      default: begin
        start_sample_s = 1'b0;
        data_sample_s  = 1'b0;
        stop_sample_s  = 1'b0;
      end
    endcase
    byte_ok_s   = stop_sample_s & rx_sync_q;
    frame_bad_s = stop_sample_s & ~rx_sync_q;
    full_word_s = place_byte(word_q, shift_q, byte_cnt_q);
    word_done_s = byte_ok_s && (byte_cnt_q == 2'd3);
    term_s      = word_done_s && (full_word_s == END_WORD);
    write_s     = word_done_s && !term_s;
  end

  // datapath next-state: bit timing, byte assembly, word packing, write port
  always_comb begin
    cnt_d = cnt_q;
    case (state_q)
      S_START, S_DATA, S_STOP: begin
        if (start_sample_s || data_sample_s || stop_sample_s) cnt_d = '0;
        else                                                  cnt_d = cnt_q + CNT_W'(1);
      end
      default: cnt_d = '0;
    endcase

    if (data_sample_s)          bit_idx_d = bit_idx_q + 3'd1;
    else if (state_q == S_IDLE) bit_idx_d = 3'd0;
    else                        bit_idx_d = bit_idx_q;

    if (data_sample_s) shift_d = {rx_sync_q, shift_q[7:1]};
    else               shift_d = shift_q;

    // a framing error leaves byte_cnt and word untouched so the word resumes in place
    if (byte_ok_s) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      word_d     = full_word_s;
    end else begin
      byte_cnt_d = byte_cnt_q;
      word_d     = word_q;
    end

    we_d = write_s;
    if (write_s) wdata_d = full_word_s;
    else         wdata_d = wdata_q;

    if (we_q) addr_d = addr_q + ADDR_W'(1);
    else      addr_d = addr_q;

    ready_d = (state_d != S_DONE);
    done_d  = done_q | term_s;
    ferr_d  = ferr_q | frame_bad_s;
  end

  // datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      byte_cnt_q <= 2'd0;
      word_q     <= 32'h0000_0000;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'h0000_0000;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
    end
  end

  assign ready_o     = ready_q;
  assign we_o        = we_q;
  assign addr_o      = addr_q;
  assign wdata_o     = wdata_q;
  assign done_o      = done_q;
  assign frame_err_o = ferr_q;

endmodule

// File: tb/tb_uart_prog_rx.sv
// Directed bench for uart_prog_rx: two instances (ADDR_W=10 and ADDR_W=2) share rx and reset.
module tb_uart_prog_rx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx;

  logic        ready_a, we_a, done_a, ferr_a;
  logic [9:0]  addr_a;
  logic [31:0] wdata_a;
  logic        ready_b, we_b, done_b, ferr_b;
  logic [1:0]  addr_b;
  logic [31:0] wdata_b;

  always #5 clk = ~clk;

  uart_prog_rx #(.CLKS_PER_BIT(CPB), .ADDR_W(10), .END_WORD(32'h0000_0FFF)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .rx_i(rx),
    .ready_o(ready_a), .we_o(we_a), .addr_o(addr_a), .wdata_o(wdata_a),
    .done_o(done_a), .frame_err_o(ferr_a)
  );

  uart_prog_rx #(.CLKS_PER_BIT(CPB), .ADDR_W(2), .END_WORD(32'h0000_0FFF)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .rx_i(rx),
    .ready_o(ready_b), .we_o(we_b), .addr_o(addr_b), .wdata_o(wdata_b),
    .done_o(done_b), .frame_err_o(ferr_b)
  );

  int n_asserts = 0;
  int n_fail    = 0;

  int          wr_cnt_a = 0;
  int          wr_cnt_b = 0;
  logic [9:0]  wr_addr_a [16];
  logic [31:0] wr_data_a [16];
  logic [1:0]  wr_addr_b [16];
  logic [31:0] wr_data_b [16];
  int          dbl_we   = 0;
  int          overlap  = 0;
  int          data_chg = 0;
  logic        we_a_prev    = 1'b0;
  logic [31:0] wdata_a_prev = 32'h0;
  logic        rst_prev     = 1'b0;

  // write logger and running protocol monitors
  always @(negedge clk) begin
    if (we_a) begin
      if (wr_cnt_a < 16) begin
        wr_addr_a[wr_cnt_a] = addr_a;
        wr_data_a[wr_cnt_a] = wdata_a;
      end
      wr_cnt_a++;
    end
    if (we_b) begin
      if (wr_cnt_b < 16) begin
        wr_addr_b[wr_cnt_b] = addr_b;
        wr_data_b[wr_cnt_b] = wdata_b;
      end
      wr_cnt_b++;
    end
    if (we_a && we_a_prev) dbl_we++;
    if (done_a && ready_a) overlap++;
    if (rst_n && rst_prev && !we_a && (wdata_a != wdata_a_prev)) data_chg++;
    we_a_prev    = we_a;
    wdata_a_prev = wdata_a;
    rst_prev     = rst_n;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0],   1'b1);
    send_byte(w[15:8],  1'b1);
    send_byte(w[23:16], 1'b1);
    send_byte(w[31:24], 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready",  {31'd0, ready_a}, 32'd0);
    check("rst_we",     {31'd0, we_a},    32'd0);
    check("rst_addr",   {22'd0, addr_a},  32'd0);
    check("rst_wdata",  wdata_a,          32'd0);
    check("rst_done",   {31'd0, done_a},  32'd0);
    check("rst_ferr",   {31'd0, ferr_a},  32'd0);
    check("rst_addr_b", {30'd0, addr_b},  32'd0);

    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", {31'd0, ready_a}, 32'd1);
    repeat (4) @(negedge clk);

    // one-cycle low glitch in IDLE
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (12) @(negedge clk);
    check("glitch_no_write", wr_cnt_a,         32'd0);
    check("glitch_ferr",     {31'd0, ferr_a},  32'd0);

    send_word(32'h0000_449A);
    check("w0_count",  wr_cnt_a,        32'd1);
    check("w0_addr",   {22'd0, wr_addr_a[0]}, 32'd0);
    check("w0_data",   wr_data_a[0],    32'h0000_449A);
    check("w0_addr_inc", {22'd0, addr_a}, 32'd1);
    check("w0_wdata_hold", wdata_a,     32'h0000_449A);

    // bad stop bit on a lone byte, then a clean word
    send_byte(8'h12, 1'b0);
    check("ferr_set",       {31'd0, ferr_a}, 32'd1);
    check("ferr_no_write",  wr_cnt_a,        32'd1);
    send_word(32'h7856_3412);
    check("w1_count", wr_cnt_a,              32'd2);
    check("w1_addr",  {22'd0, wr_addr_a[1]}, 32'd1);
    check("w1_data",  wr_data_a[1],          32'h7856_3412);

    // frame error in the middle of a word keeps the byte position
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    send_byte(8'hDD, 1'b1);
    send_byte(8'hEE, 1'b1);
    check("w2_count", wr_cnt_a,              32'd3);
    check("w2_addr",  {22'd0, wr_addr_a[2]}, 32'd2);
    check("w2_data",  wr_data_a[2],          32'hEEDD_CCAA);

    send_word(32'h1122_3344);
    send_word(32'h8877_6655);
    check("b_count",      wr_cnt_b,              32'd5);
    check("b_w4_addr",    {30'd0, wr_addr_b[4]}, 32'd0);
    check("b_w4_data",    wr_data_b[4],          32'h8877_6655);
    check("b_w3_addr",    {30'd0, wr_addr_b[3]}, 32'd3);
    check("a_w4_addr",    {22'd0, wr_addr_a[4]}, 32'd4);
    check("b_addr_wrap",  {30'd0, addr_b},       32'd1);
    check("a_addr_next",  {22'd0, addr_a},       32'd5);

    // reset after two bytes of a word
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_we",     {31'd0, we_a},    32'd0);
    check("mid_rst_addr",   {22'd0, addr_a},  32'd0);
    check("mid_rst_wdata",  wdata_a,          32'd0);
    check("mid_rst_ready",  {31'd0, ready_a}, 32'd0);
    check("mid_rst_ferr",   {31'd0, ferr_a},  32'd0);
    check("mid_rst_addr_b", {30'd0, addr_b},  32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_ready_up", {31'd0, ready_a}, 32'd1);

    send_word(32'hD4C3_B2A1);
    check("pr_w0_count", wr_cnt_a,              32'd6);
    check("pr_w0_addr",  {22'd0, wr_addr_a[5]}, 32'd0);
    check("pr_w0_data",  wr_data_a[5],          32'hD4C3_B2A1);

    // words one bit or one byte away from the terminator are ordinary data
    send_word(32'h0000_0FFE);
    send_word(32'h0F00_0FFF);
    check("pr_count3",  wr_cnt_a,              32'd8);
    check("pr_w1_data", wr_data_a[6],          32'h0000_0FFE);
    check("pr_w2_addr", {22'd0, wr_addr_a[7]}, 32'd2);
    check("pr_w2_data", wr_data_a[7],          32'h0F00_0FFF);
    check("pre_term_done",  {31'd0, done_a},   32'd0);
    check("pre_term_ready", {31'd0, ready_a},  32'd1);

    send_word(32'h0000_0FFF);
    check("term_done",      {31'd0, done_a},  32'd1);
    check("term_ready",     {31'd0, ready_a}, 32'd0);
    check("term_not_written", wr_cnt_a,       32'd8);
    check("term_addr",      {22'd0, addr_a},  32'd3);
    check("term_addr_b",    {30'd0, addr_b},  32'd3);
    check("term_wdata",     wdata_a,          32'h0F00_0FFF);

    send_word(32'h0102_0304);
    send_byte(8'h55, 1'b0);
    check("done_no_write",   wr_cnt_a,        32'd8);
    check("done_no_write_b", wr_cnt_b,        32'd8);
    check("done_sticky",     {31'd0, done_a}, 32'd1);
    check("done_ignore_ferr", {31'd0, ferr_a}, 32'd0);

    check("we_single_cycle", dbl_we,   32'd0);
    check("done_ready_overlap", overlap, 32'd0);
    check("wdata_stable",    data_chg, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
